// File: rtl/mtr_pkg.sv
// Shared types and helpers for the wheel motor-drive front end.
// Holds direction/state enums, duty width constants and the bounded
// duty stepping function used by the slew-limited drive.
package mtr_pkg;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_FWD,
        DIR_REV
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RAMP_DN,
        DEAD
    } state_t;

    localparam int              DUTY_W   = 11;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'h7FF;

    // Move cur toward goal by at most step, never passing the goal.
    // The upward sum is one bit wider so a ramp near full scale cannot wrap,
    // and the downward path only subtracts when the gap exceeds the step.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] goal,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W:0]   up;
        logic [DUTY_W-1:0] gap;
        step_toward = cur;
        up          = {1'b0, cur} + {1'b0, step};
        gap         = '0;
        if (cur < goal) begin
            step_toward = (up > {1'b0, goal}) ? goal : up[DUTY_W-1:0];
        end else if (cur > goal) begin
            gap         = cur - goal;
            step_toward = (gap > step) ? (cur - step) : goal;
        end
    endfunction

endpackage

// File: rtl/slew_tick_gen.sv
// Free-running prescaler that marks the start of each slew period.
// The counter wraps on its own and is only cleared by reset, so new
// speed commands never shift the slew grid.
module slew_tick_gen #(
    parameter int DIV = 2048
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // Count 0..DIV-1 and wrap to 0 on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mtr_slew_drv.sv
// Slew-limited duty and H-bridge direction control for one wheel.
// Converts the signed speed command into an unsigned duty that changes by at
// most SLEW_STEP per slew tick, ramping to zero and holding a dead time with
// both bridge enables low before any direction change.
// Build option: MTR_DEADBAND_EN adds MIN_DUTY to every nonzero goal in RUN.
module mtr_slew_drv
    import mtr_pkg::*;
#(
    parameter int SLEW_DIV    = 2048,
    parameter int SLEW_STEP   = 16,
    parameter int DEAD_CYCLES = 1024,
    parameter int MIN_DUTY    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       spd,
    input  logic              spd_vld,
    output logic [DUTY_W-1:0] duty,
    output logic              fwd,
    output logic              rev,
    output logic              busy
);

    localparam int GW  = DUTY_W + 1;
    localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

`ifdef MTR_DEADBAND_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic              tick;
    logic [11:0]       spd_abs;
    logic [DUTY_W-1:0] spd_mag;
    dir_t              spd_dir;
    logic [DUTY_W-1:0] tgt_mag;
    dir_t              tgt_dir;
    logic [GW-1:0]     mag_off;
    logic [DUTY_W-1:0] goal;
    state_t            state, state_nxt;
    dir_t              cur_dir, cur_dir_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic [DCW-1:0]    dead_cnt, dead_cnt_nxt;

    slew_tick_gen #(
        .DIV (SLEW_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Magnitude and direction of the incoming command; -2048 has no positive
    // 11-bit counterpart, so its magnitude clamps to full scale.
    always_comb begin
        spd_abs = spd[11] ? (~spd + 12'd1) : spd;
        spd_mag = spd_abs[11] ? DUTY_MAX : spd_abs[DUTY_W-1:0];
        if (spd == 12'd0) begin
            spd_dir = DIR_NONE;
        end else if (spd[11]) begin
            spd_dir = DIR_REV;
        end else begin
            spd_dir = DIR_FWD;
        end
    end

    // Hold the most recent command; a new strobe overrides it in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_mag <= '0;
            tgt_dir <= DIR_NONE;
        end else if (spd_vld) begin
            tgt_mag <= spd_mag;
            tgt_dir <= spd_dir;
        end
    end

    // Running goal: the command magnitude, optionally lifted past the motor
    // deadband; a zero target always stays at zero.
    always_comb begin
        mag_off = {1'b0, tgt_mag} + GW'(MIN_DUTY);
        goal    = tgt_mag;
        if (DB_EN && (tgt_mag != '0)) begin
            goal = (mag_off > {1'b0, DUTY_MAX}) ? DUTY_MAX : mag_off[DUTY_W-1:0];
        end
    end

    // Sequence the bridge: dead time before energising, slew while running,
    // ramp to zero before any reversal or stop.
    always_comb begin
        state_nxt    = state;
        cur_dir_nxt  = cur_dir;
        duty_nxt     = duty;
        dead_cnt_nxt = dead_cnt;
        case (state)
            IDLE: begin
                duty_nxt    = '0;
                cur_dir_nxt = DIR_NONE;
                if (tgt_dir != DIR_NONE) begin
                    state_nxt    = DEAD;
                    dead_cnt_nxt = '0;
                end
            end
            RUN: begin
                if (tgt_dir == cur_dir) begin
                    if (tick) begin
                        duty_nxt = step_toward(duty, goal, DUTY_W'(SLEW_STEP));
                    end
                end else if ((tgt_dir == DIR_NONE) && (duty == '0)) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RAMP_DN;
                end
            end
            RAMP_DN: begin
                if (tgt_dir == cur_dir) begin
                    state_nxt = RUN;
                end else if (duty == '0) begin
                    if (tgt_dir == DIR_NONE) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt    = DEAD;
                        dead_cnt_nxt = '0;
                    end
                end else if (tick) begin
                    duty_nxt = step_toward(duty, '0, DUTY_W'(SLEW_STEP));
                end
            end
            DEAD: begin
                duty_nxt = '0;
                if (dead_cnt == DCW'(DEAD_CYCLES - 1)) begin
                    cur_dir_nxt = tgt_dir;
                    state_nxt   = (tgt_dir == DIR_NONE) ? IDLE : RUN;
                end else begin
                    dead_cnt_nxt = dead_cnt + DCW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                duty_nxt  = '0;
            end
        endcase
    end

    // State, direction, dead-time counter and duty registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_dir  <= DIR_NONE;
            dead_cnt <= '0;
            duty     <= '0;
        end else begin
            state    <= state_nxt;
            cur_dir  <= cur_dir_nxt;
            dead_cnt <= dead_cnt_nxt;
            duty     <= duty_nxt;
        end
    end

    // Bridge enables follow the registered state, so fwd and rev can never
    // both be high and both drop during DEAD and IDLE.
    always_comb begin
        fwd  = ((state == RUN) || (state == RAMP_DN)) && (cur_dir == DIR_FWD);
        rev  = ((state == RUN) || (state == RAMP_DN)) && (cur_dir == DIR_REV);
        busy = (state == RAMP_DN) || (state == DEAD);
    end

endmodule

// File: tb/tb_mtr_slew_drv.sv
// Self-checking bench for mtr_slew_drv with a short slew period and dead time.
// Expected output changes ({fwd,rev,duty}) are queued as commands are issued
// and compared in order whenever the DUT outputs change.
module tb_mtr_slew_drv;

    localparam int DIV   = 8;
    localparam int STEP  = 16;
    localparam int DEADC = 20;
    localparam int MIND  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] spd;
    logic        spd_vld;
    logic [10:0] duty;
    logic        fwd;
    logic        rev;
    logic        busy;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [12:0] sbQ[$];
    int          mDuty;
    int          mDir;
    logic [12:0] prevOut = '0;
    logic [12:0] monCur;
    logic        prevEn = 1'b0;
    int          busyRun = 0;

    mtr_slew_drv #(
        .SLEW_DIV    (DIV),
        .SLEW_STEP   (STEP),
        .DEAD_CYCLES (DEADC),
        .MIN_DUTY    (MIND)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spd     (spd),
        .spd_vld (spd_vld),
        .duty    (duty),
        .fwd     (fwd),
        .rev     (rev),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        testsRun++;
        if (obs != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int goalOf(input int mag);
        int g;
        g = mag;
`ifdef MTR_DEADBAND_EN
        if (mag != 0) g = (mag + MIND > 2047) ? 2047 : mag + MIND;
`endif
        return g;
    endfunction

    task automatic pushEvt();
        sbQ.push_back({(mDir == 1), (mDir == 2), 11'(mDuty)});
    endtask

    task automatic pushRamp(input int g);
        while (mDuty != g) begin
            if (mDuty < g) mDuty = (mDuty + STEP > g) ? g : mDuty + STEP;
            else           mDuty = (mDuty - STEP < g) ? g : mDuty - STEP;
            pushEvt();
        end
    endtask

    task automatic cmdExpect(input int s);
        int mag;
        int nd;
        mag = (s < 0) ? -s : s;
        if (mag > 2047) mag = 2047;
        nd = (s > 0) ? 1 : ((s < 0) ? 2 : 0);
        if (nd != 0 && nd == mDir) begin
            pushRamp(goalOf(mag));
        end else begin
            if (mDir != 0) begin
                pushRamp(0);
                mDir = 0;
                pushEvt();
            end
            if (nd != 0) begin
                mDir = nd;
                pushEvt();
                pushRamp(goalOf(mag));
            end
        end
    endtask

    task automatic applyStimulus(input int s);
        @(posedge clk);
        #1;
        spd     = 12'(s);
        spd_vld = 1'b1;
        @(posedge clk);
        #1;
        spd_vld = 1'b0;
    endtask

    task automatic waitDrain(input int maxCyc);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        repeat (3 * DIV) @(negedge clk);
        checkOutput("drain", sbQ.size(), 0);
        sbQ.delete();
    endtask

    task automatic waitDuty(input int val, input int maxCyc);
        int n;
        n = 0;
        while (int'(duty) != val && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_duty", int'(duty), val);
    endtask

    // Monitor: compare every output change against the scoreboard, and track
    // the length of each both-enables-low busy window before energising.
    always @(negedge clk) begin
        monCur = {fwd, rev, duty};
        checkOutput("fwd_rev_excl", int'(fwd & rev), 0);
        if (monCur !== prevOut) begin
            if (sbQ.size() == 0) checkOutput("unexpected_out", int'(monCur), int'(prevOut));
            else                 checkOutput("out_seq", int'(monCur), int'(sbQ.pop_front()));
            if (!fwd && !rev) checkOutput("duty_zero_off", int'(duty), 0);
            prevOut = monCur;
        end
        if ((fwd || rev) && !prevEn) checkOutput("dead_len", busyRun, DEADC);
        if (busy && !fwd && !rev) busyRun++;
        else                      busyRun = 0;
        prevEn = fwd || rev;
    end

    initial begin
        rst_n   = 1'b0;
        spd     = '0;
        spd_vld = 1'b0;
        mDuty   = 0;
        mDir    = 0;
        #2;
        checkOutput("rst_duty", int'(duty), 0);
        checkOutput("rst_fwd",  int'(fwd), 0);
        checkOutput("rst_rev",  int'(rev), 0);
        checkOutput("rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start from standstill forward.
        cmdExpect(200);
        applyStimulus(200);
        waitDrain(2000);
        checkOutput("t1_duty", int'(duty), goalOf(200));
        checkOutput("t1_fwd",  int'(fwd), 1);
        checkOutput("t1_rev",  int'(rev), 0);

        // Reversal to -100.
        cmdExpect(-100);
        applyStimulus(-100);
        waitDrain(2000);
        checkOutput("t2_duty", int'(duty), goalOf(100));
        checkOutput("t2_rev",  int'(rev), 1);
        checkOutput("t2_fwd",  int'(fwd), 0);

        // Full-scale reverse then full-scale forward.
        cmdExpect(-2048);
        applyStimulus(-2048);
        waitDrain(5000);
        checkOutput("t3_sat_duty", int'(duty), 2047);
        cmdExpect(2047);
        applyStimulus(2047);
        waitDrain(5000);
        checkOutput("t3_fwd_duty", int'(duty), 2047);
        checkOutput("t3_fwd", int'(fwd), 1);

        // Abort a ramp-down by returning to the running direction.
        cmdExpect(200);
        applyStimulus(200);
        waitDrain(5000);
        pushRamp(104);
        applyStimulus(-100);
        waitDuty(104, 500);
        pushRamp(goalOf(150));
        applyStimulus(150);
        waitDrain(2000);
        checkOutput("t4_duty", int'(duty), goalOf(150));
        checkOutput("t4_fwd",  int'(fwd), 1);
        checkOutput("t4_busy", int'(busy), 0);

        // Stop, restart, then reset in the middle of the ramp.
        cmdExpect(0);
        applyStimulus(0);
        waitDrain(2000);
        checkOutput("t5_idle_busy", int'(busy), 0);
        checkOutput("t5_idle_fwd",  int'(fwd), 0);
        mDir = 1;
        pushEvt();
        pushRamp(64);
        mDir  = 0;
        mDuty = 0;
        pushEvt();
        applyStimulus(200);
        waitDuty(64, 500);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_duty", int'(duty), 0);
        checkOutput("t5_rst_fwd",  int'(fwd), 0);
        checkOutput("t5_rst_rev",  int'(rev), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * DEADC + 4 * DIV) @(negedge clk);
        checkOutput("t5_post_duty", int'(duty), 0);
        checkOutput("t5_post_fwd",  int'(fwd), 0);
        checkOutput("t5_post_busy", int'(busy), 0);
        checkOutput("t5_post_q",    sbQ.size(), 0);

        // Small command (deadband lift when enabled), then stop to IDLE.
        cmdExpect(10);
        applyStimulus(10);
        waitDrain(2000);
        checkOutput("t6_duty", int'(duty), goalOf(10));
        cmdExpect(0);
        applyStimulus(0);
        waitDrain(2000);
        checkOutput("t6_zero_duty", int'(duty), 0);
        checkOutput("t6_idle_busy", int'(busy), 0);
        checkOutput("t6_idle_fwd",  int'(fwd), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
